// File: rtl/ifu_fetch_pkg.sv
// Shared constants and helpers for the instruction fetch unit (ifu_fetch).
package ifu_fetch_pkg;

   localparam int                   CPU_WIDTH        = 32;
   localparam int                   IFU_FIFO_DEPTH   = 2;
   localparam logic [CPU_WIDTH-1:0] INST_NOP         = 32'h0000_0013;
   localparam logic [CPU_WIDTH-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [CPU_WIDTH-1:0] PC_ALIGN_MASK    = 32'hFFFF_FFFC;
   localparam logic [CPU_WIDTH-1:0] PC_STEP          = 32'h0000_0004;

   function automatic logic [CPU_WIDTH-1:0] align_pc(input logic [CPU_WIDTH-1:0] pc);
      return pc & PC_ALIGN_MASK;
   endfunction

endpackage

// File: rtl/ifu_fetch_if.sv
// Instruction-memory and decode-side handshake bundle for ifu_fetch.
interface ifu_fetch_if;
   import ifu_fetch_pkg::*;

   logic                 imem_req;
   logic [CPU_WIDTH-1:0] imem_addr;
   logic                 imem_gnt;
   logic                 imem_rvalid;
   logic [CPU_WIDTH-1:0] imem_rdata;
   logic                 id_valid;
   logic                 id_ready;
   logic [CPU_WIDTH-1:0] id_inst;
   logic [CPU_WIDTH-1:0] id_pc;

   modport master (
      output imem_req, imem_addr, id_valid, id_inst, id_pc,
      input  imem_gnt, imem_rvalid, imem_rdata, id_ready
   );

   modport slave (
      input  imem_req, imem_addr, id_valid, id_inst, id_pc,
      output imem_gnt, imem_rvalid, imem_rdata, id_ready
   );

endinterface

// File: rtl/ifu_fetch_fifo.sv
// Small synchronous FIFO with flush and occupancy count; DEPTH must be a power of two.
module ifu_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic [CW-1:0]    count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [CW-1:0]    count_r;
   logic             push_s;
   logic             pop_s;

   // Qualify requests against occupancy so the pointers never cross.
   always_comb begin
      pop_s  = pop & (count_r != '0);
      push_s = push & ((count_r != CW'(DEPTH)) | pop_s);
   end

   // Storage, pointers and count; flush empties without touching storage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
      end else if (flush) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (push_s) begin
            mem_r[wr_ptr_r] <= wdata;
            wr_ptr_r        <= wr_ptr_r + AW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         count_r <= count_r + CW'(push_s) - CW'(pop_s);
      end
   end

   assign rdata = mem_r[rd_ptr_r];
   assign count = count_r;

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: PC, credit-limited imem requests, fetch buffer, redirect flush.
// Optional macro IFU_BYPASS_EN gives a zero-latency path from imem to decode when the buffer is empty.
module ifu_fetch
   import ifu_fetch_pkg::*;
#(
   parameter logic [CPU_WIDTH-1:0] RESET_PC   = RESET_PC_DEFAULT,
   parameter int                   FIFO_DEPTH = IFU_FIFO_DEPTH
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 redirect_valid,
   input  logic [CPU_WIDTH-1:0] redirect_pc,
   ifu_fetch_if.master          bus
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int SW = CW + 1;

   logic [CPU_WIDTH-1:0]   pc_r;
   logic [CPU_WIDTH-1:0]   pc_nxt_s;
   logic                   req_r;
   logic                   req_nxt_s;
   logic [CW-1:0]          discard_r;
   logic [CW-1:0]          discard_nxt_s;
   logic [CW-1:0]          inflight_s;
   logic [CW-1:0]          inflight_nxt_s;
   logic [CW-1:0]          fifo_count_s;
   logic [CW-1:0]          fifo_count_nxt_s;
   logic                   grant_s;
   logic                   resp_s;
   logic                   drop_s;
   logic                   bypass_s;
   logic                   push_s;
   logic                   pop_s;
   logic [2*CPU_WIDTH-1:0] head_s;
   logic [CPU_WIDTH-1:0]   tag_s;

   // Transfer events for this cycle; redirect overrides push, pop and pc increment.
   always_comb begin
      grant_s = req_r & bus.imem_gnt;
      resp_s  = bus.imem_rvalid & (inflight_s != '0);
      drop_s  = resp_s & (redirect_valid | (discard_r != '0));
`ifdef IFU_BYPASS_EN
      bypass_s = resp_s & ~drop_s & (fifo_count_s == '0);
`else
      bypass_s = 1'b0;
`endif
      pop_s  = ~redirect_valid & bus.id_ready & (fifo_count_s != '0);
      push_s = resp_s & ~drop_s & ~(bypass_s & bus.id_ready);
   end

   // Next-state bookkeeping; the request flop looks at next-cycle credit.
   always_comb begin
      inflight_nxt_s = inflight_s + CW'(grant_s) - CW'(resp_s);
      if (redirect_valid) begin
         fifo_count_nxt_s = '0;
         discard_nxt_s    = inflight_nxt_s;
         pc_nxt_s         = align_pc(redirect_pc);
      end else begin
         fifo_count_nxt_s = fifo_count_s + CW'(push_s) - CW'(pop_s);
         discard_nxt_s    = discard_r - CW'(resp_s & (discard_r != '0));
         pc_nxt_s         = grant_s ? (pc_r + PC_STEP) : pc_r;
      end
      req_nxt_s = ({1'b0, fifo_count_nxt_s} + {1'b0, inflight_nxt_s}) < SW'(FIFO_DEPTH);
   end

   // PC, request and discard counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_r      <= RESET_PC;
         req_r     <= 1'b0;
         discard_r <= '0;
      end else begin
         pc_r      <= pc_nxt_s;
         req_r     <= req_nxt_s;
         discard_r <= discard_nxt_s;
      end
   end

   // Tag queue occupancy doubles as the in-flight count, discarded requests included.
   ifu_fifo #(
      .WIDTH (CPU_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_tag_q (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (1'b0),
      .push  (grant_s),
      .pop   (resp_s),
      .wdata (pc_r),
      .rdata (tag_s),
      .count (inflight_s)
   );

   ifu_fifo #(
      .WIDTH (2 * CPU_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_data_q (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (redirect_valid),
      .push  (push_s),
      .pop   (pop_s),
      .wdata ({bus.imem_rdata, tag_s}),
      .rdata (head_s),
      .count (fifo_count_s)
   );

   assign bus.imem_req  = req_r;
   assign bus.imem_addr = pc_r;

   // Decode-side view: buffer head, else bypassed response, else a harmless nop.
   always_comb begin
      bus.id_valid = 1'b0;
      bus.id_inst  = INST_NOP;
      bus.id_pc    = '0;
      if (fifo_count_s != '0) begin
         bus.id_valid = 1'b1;
         bus.id_inst  = head_s[2*CPU_WIDTH-1:CPU_WIDTH];
         bus.id_pc    = head_s[CPU_WIDTH-1:0];
      end else if (bypass_s) begin
         bus.id_valid = 1'b1;
         bus.id_inst  = bus.imem_rdata;
         bus.id_pc    = tag_s;
      end else begin
         bus.id_valid = 1'b0;
      end
   end

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: directed phases plus randomized traffic against a queue model.
module tb_ifu_fetch;

   localparam int          DEPTH   = 2;
   localparam logic [31:0] RST_PC  = 32'h0000_0000;
   localparam logic [31:0] NOP     = 32'h0000_0013;

   typedef struct {
      logic [31:0] addr;
      bit          live;
   } ent_t;

   logic        clk;
   logic        rst_n;
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   ifu_fetch_if bus ();

   ifu_fetch #(
      .RESET_PC   (RST_PC),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .bus            (bus)
   );

   int          n_vec;
   int          n_bad;
   ent_t        memq[$];
   logic [31:0] bufq[$];
   logic [31:0] fetch_pc;
   logic [31:0] exp_pc;
   bit          started;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      memq.delete();
      bufq.delete();
      fetch_pc = RST_PC;
      exp_pc   = RST_PC;
      started  = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_req"},   32'(bus.imem_req), 32'd0);
      chk({tag, "_addr"},  bus.imem_addr,     RST_PC);
      chk({tag, "_valid"}, 32'(bus.id_valid), 32'd0);
      chk({tag, "_inst"},  bus.id_inst,       NOP);
      chk({tag, "_pc"},    bus.id_pc,         32'd0);
   endtask

   // One clock: drive, check at negedge, advance the model at posedge.
   task automatic cyc(input bit gnt, input bit rdy, input bit redir,
                      input logic [31:0] rpc, input int unsigned rv_pct);
      bit   ev_grant;
      bit   ev_resp;
      bit   ev_cons;
      bit   exp_req;
      ent_t ent;
      bus.imem_gnt   = gnt;
      bus.id_ready   = rdy;
      redirect_valid = redir;
      redirect_pc    = rpc;
      if (memq.size() > 0) begin
         bus.imem_rvalid = ($urandom_range(99) < rv_pct);
         bus.imem_rdata  = mem_word(memq[0].addr);
      end else begin
         bus.imem_rvalid = (rv_pct != 0) && ($urandom_range(99) < 10);
         bus.imem_rdata  = $urandom();
      end
      @(negedge clk);
      exp_req = started && ((bufq.size() + memq.size()) < DEPTH);
      chk("imem_req", 32'(bus.imem_req), 32'(exp_req));
      if (bus.imem_req) chk("imem_addr", bus.imem_addr, fetch_pc);
      chk("id_valid", 32'(bus.id_valid), 32'(bufq.size() > 0));
      if (bufq.size() > 0) begin
         chk("id_pc", bus.id_pc, bufq[0]);
         chk("id_inst", bus.id_inst, mem_word(bufq[0]));
      end else begin
         chk("idle_inst", bus.id_inst, NOP);
         chk("idle_pc", bus.id_pc, 32'd0);
      end
      ev_grant = bus.imem_req && gnt;
      ev_resp  = bus.imem_rvalid && (memq.size() > 0);
      ev_cons  = bus.id_valid && rdy && !redir;
      if (ev_cons) chk("stream_pc", bus.id_pc, exp_pc);
      @(posedge clk);
      if (ev_cons && bufq.size() > 0) begin
         void'(bufq.pop_front());
         exp_pc = exp_pc + 32'd4;
      end
      if (ev_resp) begin
         ent = memq.pop_front();
         if (ent.live && !redir) bufq.push_back(ent.addr);
      end
      if (ev_grant) begin
         memq.push_back('{addr: fetch_pc, live: 1'b1});
         fetch_pc = fetch_pc + 32'd4;
      end
      if (redir) begin
         foreach (memq[i]) memq[i].live = 1'b0;
         bufq.delete();
         fetch_pc = rpc & 32'hFFFF_FFFC;
         exp_pc   = rpc & 32'hFFFF_FFFC;
      end
      started = 1'b1;
      #1;
   endtask

   initial begin
      int cnt;
      n_vec = 0;
      n_bad = 0;
      rst_n           = 1'b0;
      redirect_valid  = 1'b0;
      redirect_pc     = 32'd0;
      bus.imem_gnt    = 1'b0;
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = 32'd0;
      bus.id_ready    = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("rst");
      rst_n = 1'b1;

      // Streaming with immediate responses and an always-ready decoder.
      repeat (12) cyc(1'b1, 1'b1, 1'b0, 32'd0, 100);

      // Decode stalls: credit stops requests once the buffer is full.
      repeat (10) cyc(1'b1, 1'b0, 1'b0, 32'd0, 100);
      chk("stall_valid", 32'(bus.id_valid), 32'd1);
      chk("stall_req", 32'(bus.imem_req), 32'd0);
      repeat (8) cyc(1'b1, 1'b1, 1'b0, 32'd0, 100);

      // Two requests in flight, then redirect to 0x100.
      cnt = 0;
      while (memq.size() < 2 && cnt < 20) begin
         cyc(1'b1, 1'b1, 1'b0, 32'd0, 0);
         cnt++;
      end
      chk("two_inflight_bound", 32'(memq.size()), 32'd2);
      cyc(1'b0, 1'b1, 1'b1, 32'h0000_0100, 0);
      repeat (10) cyc(1'b1, 1'b1, 1'b0, 32'd0, 100);

      // Pending ungranted request retargeted by a misaligned redirect.
      repeat (4) cyc(1'b0, 1'b1, 1'b0, 32'd0, 100);
      cyc(1'b0, 1'b1, 1'b1, 32'h0000_0203, 100);
      chk("retarget_addr", bus.imem_addr, 32'h0000_0200);
      chk("retarget_req", 32'(bus.imem_req), 32'd1);
      repeat (6) cyc(1'b1, 1'b1, 1'b0, 32'd0, 100);

      // Redirect together with a response and a grant.
      repeat (5) cyc(1'b0, 1'b1, 1'b0, 32'd0, 100);
      cyc(1'b1, 1'b1, 1'b0, 32'd0, 0);
      chk("collide_setup_req", 32'(bus.imem_req), 32'd1);
      cyc(1'b1, 1'b1, 1'b1, 32'h0000_0300, 100);
      repeat (10) cyc(1'b1, 1'b1, 1'b0, 32'd0, 100);

      // PC wrap from the top of the address space.
      cyc(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8, 100);
      repeat (14) cyc(1'b1, 1'b1, 1'b0, 32'd0, 100);

      // Randomized traffic with occasional redirects.
      for (int i = 0; i < 600; i++) begin
         logic [31:0] tgt;
         tgt = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom();
         cyc(1'($urandom_range(1)), 1'($urandom_range(3) != 0),
             ($urandom_range(99) < 4), tgt, 60);
      end

      // Asynchronous reset with requests in flight.
      repeat (5) cyc(1'b0, 1'b1, 1'b0, 32'd0, 100);
      cyc(1'b1, 1'b1, 1'b0, 32'd0, 0);
      cyc(1'b1, 1'b1, 1'b0, 32'd0, 0);
      chk("pre_reset_inflight", 32'(memq.size()), 32'd2);
      rst_n           = 1'b0;
      bus.imem_gnt    = 1'b0;
      bus.imem_rvalid = 1'b0;
      bus.id_ready    = 1'b0;
      redirect_valid  = 1'b0;
      #1;
      check_reset_outputs("mid_rst");
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (12) cyc(1'b1, 1'b1, 1'b0, 32'd0, 100);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
